// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the memory stage.
// Misses stall the pipeline via Cache_busy while lines move word-serially over mem_req/mem_ack.
module dcache_ctrl #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] AddrM,
  input  logic [31:0]           WriteDataM,
  input  logic [3:0]            ByteEnM,
  output logic [31:0]           ReadDataM,
  output logic                  Cache_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  localparam int IDX = $clog2(NUM_LINES);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WB-1:0]        cnt_q, cnt_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  logic [TAG-1:0] tag_mem  [NUM_LINES];
  logic [31:0]    data_mem [NUM_LINES][LINE_WORDS];

  logic [TAG-1:0] tag;
  logic [IDX-1:0] index;
  logic [WB-1:0]  word;
  logic           unused_addr;
  logic           req, hit, xfer, last_beat, write_hit;

  assign tag         = AddrM[ADDR_WIDTH-1:IDX+OFF];
  assign index       = AddrM[IDX+OFF-1:OFF];
  assign word        = AddrM[OFF-1:2];
  assign unused_addr = ^AddrM[1:0];

  assign req       = MemReadM | MemWriteM;
  assign hit       = valid_q[index] && (tag_mem[index] == tag);
  assign xfer      = mem_req && mem_ack;
  assign last_beat = xfer && (cnt_q == WB'(LINE_WORDS - 1));
  assign write_hit = (state_q == IDLE) && hit && MemWriteM;

  // Bus request comes straight from the reset flop so it drops the instant rst_n falls.
  assign mem_req    = (state_q != IDLE);
  assign mem_we     = (state_q == WRITEBACK);
  assign Cache_busy = mem_req || (req && !hit);
  assign ReadDataM  = ((state_q == IDLE) && MemReadM && hit) ? data_mem[index][word] : 32'd0;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state_q)
      WRITEBACK: begin
        mem_addr  = {tag_mem[index], index, cnt_q, 2'b00};
        mem_wdata = data_mem[index][cnt_q];
      end
      REFILL:  mem_addr = {tag, index, cnt_q, 2'b00};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (xfer) cnt_d = cnt_q + WB'(1);
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          cnt_d   = '0;
          state_d = (valid_q[index] && dirty_q[index]) ? WRITEBACK : REFILL;
        end else if (write_hit) begin
          dirty_d[index] = 1'b1;
        end
      end
      WRITEBACK: begin
        if (last_beat) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (last_beat) begin
          state_d        = IDLE;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage keep their contents across reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && xfer) data_mem[index][cnt_q] <= mem_rdata;
    if ((state_q == REFILL) && last_beat) tag_mem[index] <= tag;
    if (write_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (ByteEnM[b]) data_mem[index][word][8*b +: 8] <= WriteDataM[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat-memory/line-state reference model predicts load data
// and stall lengths, a bus responder models main memory, and a monitor checks each completion.
module tb_dcache_ctrl;

  localparam int NL = 64;
  localparam int LW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MemReadM = 1'b0;
  logic          MemWriteM = 1'b0;
  logic [AW-1:0] AddrM = '0;
  logic [31:0]   WriteDataM = '0;
  logic [3:0]    ByteEnM = '0;
  logic [31:0]   ReadDataM;
  logic          Cache_busy;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;

  dcache_ctrl #(.NUM_LINES(NL), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
    .WriteDataM(WriteDataM), .ByteEnM(ByteEnM), .ReadDataM(ReadDataM),
    .Cache_busy(Cache_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          busy;
    bit          chk_busy;
  } exp_t;

  exp_t        exp_q[$];
  bit [31:0]   bus_mem  [bit [31:0]];
  bit [31:0]   arch_mem [bit [31:0]];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  bit [21:0]   m_tag   [NL];
  int          checks = 0;
  int          failures = 0;
  int          gap_len = 0;
  int          ack_total = 0;
  int          busy_cnt = 0;

  function automatic bit [31:0] init_word(bit [31:0] a);
    if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic bit [31:0] bus_rd(bit [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic bit [31:0] arch_rd(bit [31:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : init_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Dirty data that has not reached memory is lost on reset, so the architectural view reverts.
  task automatic resetModel();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    arch_mem = bus_mem;
    exp_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the request has completed.
  task automatic applyStimulus(input bit is_write, input bit [31:0] addr,
                               input bit [31:0] wd, input bit [3:0] be);
    exp_t      e;
    bit [5:0]  idx;
    bit [21:0] tg;
    bit [31:0] wa;
    bit [31:0] mask;
    int        n;
    idx = addr[9:4];
    tg  = addr[31:10];
    wa  = {addr[31:2], 2'b00};
    if (m_valid[idx] && m_tag[idx] == tg) e.busy = 0;
    else if (m_valid[idx] && m_dirty[idx]) e.busy = 2 * LW + 1;
    else e.busy = LW + 1;
    if (e.busy != 0) m_dirty[idx] = 1'b0;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (is_write) begin
      m_dirty[idx] = 1'b1;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      arch_mem[wa] = (arch_rd(wa) & ~mask) | (wd & mask);
    end
    e.is_read  = !is_write;
    e.data     = arch_rd(wa);
    e.chk_busy = (gap_len == 0);
    exp_q.push_back(e);
    MemReadM   = !is_write;
    MemWriteM  = is_write;
    AddrM      = addr;
    WriteDataM = wd;
    ByteEnM    = be;
    n = 0;
    forever begin
      @(negedge clk);
      if (!Cache_busy) break;
      n++;
      if (n > 400) begin
        failures++;
        $display("[TB] FAIL request_timeout: addr %h still busy after %0d cycles", addr, n);
        finishRun();
      end
    end
    @(posedge clk);
    #1;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  // Monitor: every cycle a request is presented without stall is one completed transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else if (MemReadM || MemWriteM) begin
      if (MemReadM && MemWriteM) begin
        failures++;
        $display("[TB] FAIL both_read_write: read and write asserted together");
      end
      if (Cache_busy) begin
        busy_cnt++;
      end else if (exp_q.size() == 0) begin
        checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (e.is_read) checkOutput("load_data", ReadDataM, e.data);
        if (e.chk_busy) checkOutput("busy_cycles", busy_cnt, e.busy);
        if (e.busy == 0) checkOutput("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
        busy_cnt = 0;
      end
    end else begin
      checkOutput("idle_busy", {31'd0, Cache_busy}, 32'd0);
      checkOutput("idle_rdata", ReadDataM, 32'd0);
      checkOutput("idle_mem_req", {31'd0, mem_req}, 32'd0);
    end
  end

  // Main-memory responder: acks after gap_len idle cycles, checks burst ordering and holds.
  int          gap_cnt = 0;
  int          beat = 0;
  bit          waiting = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'($urandom_range(0, 1));
      gap_cnt = 0;
      beat    = 0;
      waiting = 1'b0;
    end else begin
      checkOutput("burst_word", {30'd0, mem_addr[3:2]}, beat);
      if (mem_we) checkOutput("wb_index", {26'd0, mem_addr[9:4]}, {26'd0, AddrM[9:4]});
      else checkOutput("refill_line", {4'd0, mem_addr[31:4]}, {4'd0, AddrM[31:4]});
      if (waiting) checkOutput("addr_hold", mem_addr, prev_addr);
      if (gap_cnt > 0) begin
        gap_cnt--;
        mem_ack   = 1'b0;
        waiting   = 1'b1;
        prev_addr = mem_addr;
      end else begin
        mem_ack = 1'b1;
        waiting = 1'b0;
        ack_total++;
        beat    = (beat + 1) % LW;
        gap_cnt = gap_len;
        if (mem_we) begin
          checkOutput("wb_data", mem_wdata, arch_rd(mem_addr));
          bus_mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = bus_rd(mem_addr);
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    bit [31:0] a;
    resetModel();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset_busy", {31'd0, Cache_busy}, 32'd0);
    checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_rdata", ReadDataM, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    gap_len = 0;
    applyStimulus(1'b0, 32'h100, 32'd0, 4'd0);
    applyStimulus(1'b0, 32'h108, 32'd0, 4'd0);
    applyStimulus(1'b1, 32'h104, 32'h1122_3344, 4'b0011);
    applyStimulus(1'b0, 32'h104, 32'd0, 4'd0);
    applyStimulus(1'b0, 32'h100 + NL * 16, 32'd0, 4'd0);

    gap_len = 3;
    applyStimulus(1'b0, 32'h100 + 2 * NL * 16, 32'd0, 4'd0);
    gap_len = 0;

    // Abort a refill after two beats; the line must be refetched completely afterwards.
    MemReadM = 1'b1;
    AddrM    = 32'h100;
    base     = ack_total;
    n        = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((ack_total - base) < 2 && n < 100);
    if (n >= 100) checkOutput("midrefill_acks", ack_total - base, 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset_busy_held_req", {31'd0, Cache_busy}, 32'd1);
    MemReadM = 1'b0;
    #1;
    checkOutput("reset_busy_no_req", {31'd0, Cache_busy}, 32'd0);
    checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    resetModel();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h100, 32'd0, 4'd0);
    applyStimulus(1'b0, 32'h10C, 32'd0, 4'd0);

    for (int i = 0; i < 120; i++) begin
      a = ($urandom_range(0, 2) << 10) | ($urandom_range(14, 17) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      gap_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    finishRun();
  end

  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    finishRun();
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the memory stage.
- Produces Cache_busy, which the hazard unit consumes to stall fetch and decode and to flush execute.
- Serves loads and stores from the memory stage.
- Refills lines from, and writes dirty lines back to, main memory over a word-serial req/ack bus.

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.
- ADDR_WIDTH, 32, byte address width.
- Derived: OFF = log2(LINE_WORDS)+2, IDX = log2(NUM_LINES), TAG = ADDR_WIDTH-IDX-OFF.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemReadM  in  1  load request from the memory stage.
- MemWriteM  in  1  store request from the memory stage.
- AddrM  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- WriteDataM  in  32  store data.
- ByteEnM  in  4  store byte enables.
- ReadDataM  out  32  load data.
- Cache_busy  out  1  stall request to the hazard unit.
- mem_req  out  1  memory bus request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  32  writeback data.
- mem_rdata  in  32  refill data.
- mem_ack  in  1  one word transferred this cycle.

Behaviour:
- Storage: per line, valid bit, dirty bit, TAG tag bits and LINE_WORDS data words.
- Address split: tag = AddrM[ADDR_WIDTH-1:IDX+OFF], index = AddrM[IDX+OFF-1:OFF], word = AddrM[OFF-1:2].
- req = MemReadM | MemWriteM.
- hit = valid[index] & (tag_array[index] == tag).
- FSM states and transitions:
  - IDLE: on req & !hit, go to WRITEBACK if valid & dirty, else REFILL.
  - WRITEBACK: after the LINE_WORDS-th ack, go to REFILL.
  - REFILL: after the LINE_WORDS-th ack, go to IDLE.
- Cache_busy (combinational) = (state != IDLE) | (req & !hit).
  - Asserts in the same cycle as the miss.
  - Falls in the IDLE cycle after refill, when the held request now hits.
- Read hit: ReadDataM = data[index][word] combinationally, zero-cycle latency. ReadDataM = 0 when not (IDLE & MemReadM & hit).
- Write hit: when IDLE & hit & MemWriteM, the clock edge updates only the enabled bytes and sets dirty. No memory traffic.
- Write miss: allocate (writeback if needed, then refill), then complete as a write hit in the following IDLE cycle.
- MemReadM & MemWriteM both high is treated as a write; the bench flags it as an error.
- The pipeline holds AddrM, WriteDataM, ByteEnM and the request signals stable while Cache_busy = 1. The controller uses the live AddrM throughout the miss.
- Word counter cnt (log2(LINE_WORDS) bits):
  - Cleared on entering WRITEBACK or REFILL.
  - Increments on each mem_ack while mem_req = 1.
  - The transfer on which cnt == LINE_WORDS-1 is the last one; cnt wraps to 0.
- Memory bus:
  - mem_req = 1 throughout WRITEBACK/REFILL and held across words until the last ack.
  - mem_ack is ignored when mem_req = 0.
  - WRITEBACK: mem_we = 1, mem_addr = {old_tag, index, cnt, 2'b00}, mem_wdata = data[index][cnt].
  - REFILL: mem_we = 0, mem_addr = {tag, index, cnt, 2'b00}. Each ack writes mem_rdata into data[index][cnt].
  - Last REFILL ack sets valid = 1, loads the tag and clears dirty.
- Acks may arrive back-to-back (one word per cycle) or be delayed arbitrarily. Throughput is 1 word/cycle maximum.
- Miss latency with single-cycle acks:
  - Clean miss: busy for LINE_WORDS+1 cycles.
  - Dirty miss: busy for 2*LINE_WORDS+1 cycles.
- Reset (any time, including mid-burst):
  - State = IDLE, cnt = 0, all valid and dirty bits = 0.
  - mem_req = 0 immediately (asynchronously), mem_we = 0, mem_addr = 0, mem_wdata = 0, ReadDataM = 0.
  - Cache_busy = 0 unless a request is presented; after reset every request misses.
  - Data and tag arrays are not cleared.
- No request (req = 0) in IDLE: no state change, Cache_busy = 0.

Test Plan:
- Cold read: after reset, MemReadM = 1, AddrM = 0x100, memory returns 0xA0..0xA3 with 1-cycle acks.
  - Cache_busy high for 5 cycles.
  - 4 reads to 0x100, 0x104, 0x108, 0x10C.
  - Then ReadDataM = 0xA0 and Cache_busy = 0.
- Read hit: after the cold read, read 0x108 → ReadDataM = 0xA2 in the same cycle, Cache_busy = 0, no mem_req.
- Byte write hit: write 0x104 with WriteDataM = 0x11223344, ByteEnM = 4'b0011 over 0xA1 → read 0x104 returns 0x00003344, dirty set.
- Dirty eviction: read 0x100 + NUM_LINES*16 (same index, new tag).
  - 4 writes to 0x100..0x10C carrying 0xA0, 0x00003344, 0xA2, 0xA3.
  - Then 4 refill reads; Cache_busy high for 9 cycles.
- Stalled acks: 3-cycle ack gaps during refill → mem_req and mem_addr held stable between acks, and cnt advances only on ack.
- Reset mid-refill: assert rst_n = 0 after 2 acks → mem_req = 0 immediately. A re-read of 0x100 misses and issues a full 4-word refill.
